// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path: opcodes, ALU selects
// and the sequencer state encoding.
package cpu_pkg;

    localparam logic [2:0] OP_NOR  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_STA  = 3'b010;
    localparam logic [2:0] OP_JCC  = 3'b011;
    localparam logic [2:0] OP_LDA  = 3'b100;
    localparam logic [2:0] OP_NOP1 = 3'b101;
    localparam logic [2:0] OP_NOP2 = 3'b110;
    localparam logic [2:0] OP_HLT  = 3'b111;

    localparam logic [1:0] UAL_NOR  = 2'b00;
    localparam logic [1:0] UAL_ADD  = 2'b01;
    localparam logic [1:0] UAL_PASS = 2'b10;

    typedef enum logic [2:0] {
        StInit,
        StFetch,
        StDecode,
        StExec,
        StAlu,
        StHalt
    } state_e;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_NOR) || (op == OP_ADD) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the accumulator CPU: state register, strobe decode
// and retired-instruction counter.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [2:0]       code_op,
    input  logic             carry,
    output logic             load_RI,
    output logic             load_ACC,
    output logic             load_carry,
    output logic             init_carry,
    output logic [1:0]       sel_UAL,
    output logic             en_mem,
    output logic             w_mem,
    output logic             sel_ADR,
    output logic             load_PC,
    output logic             init_PC,
    output logic             inc_PC,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    logic       ri_s, acc_s, lcarry_s, icarry_s, en_s, w_s, adr_s, lpc_s, ipc_s, inc_s;
    logic [1:0] ual_s;

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        ri_s     = 1'b0;
        acc_s    = 1'b0;
        lcarry_s = 1'b0;
        icarry_s = 1'b0;
        ual_s    = UAL_NOR;
        en_s     = 1'b0;
        w_s      = 1'b0;
        adr_s    = 1'b0;
        lpc_s    = 1'b0;
        ipc_s    = 1'b0;
        inc_s    = 1'b0;
        unique case (state_q)
            StInit: begin
                ipc_s    = 1'b1;
                icarry_s = 1'b1;
                state_d  = StFetch;
            end
            StFetch: begin
                en_s    = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                ri_s    = 1'b1;
                inc_s   = 1'b1;
                state_d = StExec;
            end
            StExec: begin
                if (is_alu_op(code_op)) begin
                    adr_s   = 1'b1;
                    en_s    = 1'b1;
                    state_d = StAlu;
                end else begin
                    retire  = 1'b1;
                    state_d = (code_op == OP_HLT) ? StHalt : StFetch;
                    if (code_op == OP_STA) begin
                        adr_s = 1'b1;
                        en_s  = 1'b1;
                        w_s   = 1'b1;
                    end
                    // Conditional jump: taken on clear carry, carry is consumed either way
                    if (code_op == OP_JCC) begin
                        lpc_s    = ~carry;
                        icarry_s = 1'b1;
                    end
                end
            end
            StAlu: begin
                acc_s    = 1'b1;
                lcarry_s = (code_op == OP_ADD);
                retire   = 1'b1;
                state_d  = StFetch;
                case (code_op)
                    OP_ADD:  ual_s = UAL_ADD;
                    OP_LDA:  ual_s = UAL_PASS;
                    default: ual_s = UAL_NOR;
                endcase
            end
            StHalt: state_d = StHalt;
            default: state_d = StInit;
        endcase
    end

    assign load_RI    = ri_s & ce;
    assign load_ACC   = acc_s & ce;
    assign load_carry = lcarry_s & ce;
    assign init_carry = icarry_s & ce;
    assign sel_UAL    = ual_s & {2{ce}};
    assign en_mem     = en_s & ce;
    assign w_mem      = w_s & ce;
    assign sel_ADR    = adr_s & ce;
    assign load_PC    = lpc_s & ce;
    assign init_PC    = ipc_s & ce;
    assign inc_PC     = inc_s & ce;
    assign halted     = (state_q == StHalt);
    assign instr_cnt  = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else if (ce) begin
            state_q <= state_d;
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: expected strobe vectors and counts are queued
// as each step is driven and popped for comparison once the DUT outputs settle.
module tb_control_unit;

    localparam int unsigned CW = 4;

    localparam logic [12:0] B_RI   = 13'd1 << 12;
    localparam logic [12:0] B_ACC  = 13'd1 << 11;
    localparam logic [12:0] B_LC   = 13'd1 << 10;
    localparam logic [12:0] B_IC   = 13'd1 << 9;
    localparam logic [12:0] S_ADD  = 13'd1 << 7;
    localparam logic [12:0] S_PASS = 13'd1 << 8;
    localparam logic [12:0] B_EN   = 13'd1 << 6;
    localparam logic [12:0] B_WM   = 13'd1 << 5;
    localparam logic [12:0] B_ADR  = 13'd1 << 4;
    localparam logic [12:0] B_LPC  = 13'd1 << 3;
    localparam logic [12:0] B_IPC  = 13'd1 << 2;
    localparam logic [12:0] B_INC  = 13'd1 << 1;
    localparam logic [12:0] B_HALT = 13'd1;
    localparam logic [12:0] NONE   = 13'd0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic [2:0]    code_op = 3'b101;
    logic          carry = 1'b0;
    logic          load_RI, load_ACC, load_carry, init_carry, en_mem, w_mem, sel_ADR;
    logic          load_PC, init_PC, inc_PC, halted;
    logic [1:0]    sel_UAL;
    logic [CW-1:0] instr_cnt;
    logic [12:0]   obs;

    typedef struct {
        string         tag;
        logic [12:0]   v;
        logic [CW-1:0] c;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] m_cnt = '0;
    int            checks = 0;
    int            errors = 0;

    control_unit #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .code_op   (code_op),
        .carry     (carry),
        .load_RI   (load_RI),
        .load_ACC  (load_ACC),
        .load_carry(load_carry),
        .init_carry(init_carry),
        .sel_UAL   (sel_UAL),
        .en_mem    (en_mem),
        .w_mem     (w_mem),
        .sel_ADR   (sel_ADR),
        .load_PC   (load_PC),
        .init_PC   (init_PC),
        .inc_PC    (inc_PC),
        .halted    (halted),
        .instr_cnt (instr_cnt)
    );

    assign obs = {load_RI, load_ACC, load_carry, init_carry, sel_UAL, en_mem, w_mem,
                  sel_ADR, load_PC, init_PC, inc_PC, halted};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [12:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        e.c   = m_cnt;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s: outputs=%b expected=%b", e.tag, obs, e.v);
        end
        checks++;
        assert (instr_cnt === e.c) else begin
            errors++;
            $error("FAIL %s_cnt: instr_cnt=%0d expected=%0d", e.tag, instr_cnt, e.c);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fd(input string name);
        chk({name, "_fetch"}, B_EN);
        tick();
        chk({name, "_decode"}, B_RI | B_INC);
        tick();
    endtask

    task automatic alu_instr(input string name, input logic [2:0] op, input logic [12:0] alu_v);
        code_op = op;
        fd(name);
        chk({name, "_exec"}, B_EN | B_ADR);
        tick();
        chk({name, "_alu"}, alu_v);
        tick();
        m_cnt++;
    endtask

    task automatic short_instr(input string name, input logic [2:0] op, input logic [12:0] ex_v);
        code_op = op;
        fd(name);
        chk({name, "_exec"}, ex_v);
        tick();
        m_cnt++;
    endtask

    initial begin
        #1 rst = 1'b0;
        chk("rst_ce0", NONE);
        ce = 1'b1;
        chk("rst_ce1", B_IPC | B_IC);
        tick();
        rst = 1'b1;
        chk("init", B_IPC | B_IC);
        tick();
        short_instr("nop1", 3'b101, NONE);

        carry = 1'bx;
        alu_instr("add", 3'b001, B_ACC | B_LC | S_ADD);
        carry = 1'b0;
        alu_instr("nor", 3'b000, B_ACC);
        alu_instr("lda", 3'b100, B_ACC | S_PASS);
        short_instr("sta", 3'b010, B_EN | B_WM | B_ADR);
        carry = 1'b0;
        short_instr("jcc_c0", 3'b011, B_LPC | B_IC);
        carry = 1'b1;
        short_instr("jcc_c1", 3'b011, B_IC);
        carry = 1'b0;
        short_instr("nop2", 3'b110, NONE);

        // Stall three cycles in ALU, then let the accumulator load exactly once
        code_op = 3'b000;
        fd("stall");
        chk("stall_exec", B_EN | B_ADR);
        tick();
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_hold", NONE);
            tick();
        end
        ce = 1'b1;
        chk("stall_alu", B_ACC);
        tick();
        m_cnt++;
        chk("stall_after", B_EN);

        short_instr("hlt", 3'b111, NONE);
        chk("halt", B_HALT);
        tick();
        chk("halt_hold", B_HALT);
        ce = 1'b0;
        chk("halt_ce0", B_HALT);
        tick();
        ce = 1'b1;
        chk("halt_stay", B_HALT);
        rst = 1'b0;
        m_cnt = '0;
        chk("rst_from_halt", B_IPC | B_IC);
        tick();
        rst = 1'b1;
        chk("reinit", B_IPC | B_IC);
        tick();

        short_instr("nop3", 3'b101, NONE);
        code_op = 3'b001;
        chk("abort_fetch", B_EN);
        tick();
        chk("abort_decode", B_RI | B_INC);
        rst = 1'b0;
        m_cnt = '0;
        chk("abort_rst", B_IPC | B_IC);
        tick();
        rst = 1'b1;
        chk("abort_init", B_IPC | B_IC);
        tick();

        for (int i = 0; i < 16; i++) begin
            short_instr("wrap_nop", 3'b101, NONE);
        end
        chk("wrap_zero", B_EN);
        checks++;
        assert (instr_cnt === 4'd0) else begin
            errors++;
            $error("FAIL wrap: instr_cnt=%0d expected=0", instr_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
